fib_bcd_converter: RTL and testbench
====================================

# fib_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the Fibonacci counter. It accepts one 32-bit Fibonacci term at a time over a valid/ready handshake. It converts the term to packed decimal by shift-and-add-3 (double dabble), one bit per cycle, and presents the digits and a significant-digit count to the display/UART formatting stage.

## Interface
- WIDTH, 32, binary input width in bits.
- DIGITS, 10, number of BCD output digits. Must satisfy DIGITS ≥ ceil(WIDTH·log10 2); 10 is the value for WIDTH=32.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronised upstream.
- in_valid  input  1  in_data holds a term to convert.
- in_data  input  WIDTH  unsigned binary term.
- in_ready  output  1  converter can accept a term; high only in IDLE.
- out_valid  output  1  bcd/ndigits hold a completed result; high only in DONE.
- out_ready  input  1  downstream consumes the result.
- bcd  output  4·DIGITS  packed BCD; digit 0 (units) is in bits [3:0].
- ndigits  output  4  count of significant digits, 1..DIGITS. Equals 1 for value 0.

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers:
  - bin: WIDTH-bit shift register.
  - acc: 4·DIGITS-bit BCD accumulator.
  - cnt: bit counter, ceil(log2 WIDTH) bits.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load bin=in_data, acc=0, cnt=0; go to SHIFT.
  - in_valid without acceptance has no effect.
- SHIFT, one iteration per cycle:
  - Every 4-bit digit of acc that is ≥5 gets +3 (all digits corrected in parallel).
  - Then {acc,bin} shifts left by 1, so acc takes the MSB of bin.
  - cnt increments. On the iteration where cnt==WIDTH-1, go to DONE.
  - in_data is ignored throughout SHIFT.
- DONE:
  - out_valid=1; bcd=acc.
  - ndigits = 1 + index of the highest nonzero digit of acc, or 1 if acc==0.
  - bcd and ndigits stay stable until out_valid && out_ready. Then go to IDLE.
- No digit can overflow for legal parameters. The add-3 step is applied only to digits, never across digit boundaries.
- Full-scale input (2^WIDTH-1) is a legal input and converts exactly.
- Reset values:
  - State: IDLE.
  - Outputs: in_ready=1, out_valid=0, bcd=0, ndigits=1.
  - Registers: cnt=0, bin=0, acc=0.
- Reset asserted mid-SHIFT or mid-DONE discards the conversion. No partial result is ever presented.

## Timing
- Acceptance edge E0 (in_valid && in_ready sampled high).
- SHIFT occupies edges E1..E32 (WIDTH edges).
- out_valid is high from just after E32: 33 cycles after acceptance.
- Result consumed at edge Ec (out_valid && out_ready). in_ready is high from just after Ec.
- Minimum spacing between accepts is WIDTH+2 = 34 cycles (out_ready tied high).
- in_ready and out_valid are never high together. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Outputs are driven from registers/state only. ndigits may be decoded combinationally from acc, but must be stable whenever out_valid=1.

## Test plan
- Reset then in_data=0 → out_valid rises exactly 33 cycles after acceptance; bcd=40'h0000000000, ndigits=1.
- in_data=832040 (F30) → bcd=40'h0000832040, ndigits=6. Back-to-back term F31=1346269 with out_ready=1 → second accept exactly 34 cycles after the first; bcd=40'h0001346269, ndigits=7.
- in_data=32'hFFFFFFFF → bcd=40'h4294967295, ndigits=10. in_data=2971215073 (F47) → bcd=40'h2971215073, ndigits=10.
- Backpressure: after out_valid, hold out_ready=0 for 5 cycles while in_valid=1 with a new value. Required:
  - bcd/ndigits unchanged and in_ready=0 throughout.
  - The new value is accepted only in the cycle after out_ready is raised.
- Reset mid-operation: assert rst_n=0 at SHIFT iteration 10 of in_data=123456789. Required:
  - out_valid=0, in_ready=1 and bcd=0 immediately.
  - After release, in_data=5 → bcd=40'h0000000005, ndigits=1.
- Digit boundary: in_data=9, 10, 99, 100 → ndigits=1, 2, 2, 3; bcd low digits 0x9, 0x10, 0x99, 0x100.

Source files
------------

// File: rtl/fib_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with
// valid/ready handshakes on both sides and a significant-digit count.
module fib_bcd_converter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            ndigits
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   bin;
    logic [WIDTH-1:0]   bin_nxt;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_nxt;
    logic [BCD_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [3:0]         nd;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bin   <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            bin   <= bin_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and datapath update; add-3 correction is confined to each digit
    always_comb begin
        state_nxt = state;
        bin_nxt   = bin;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        acc_adj   = acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
        case (state)
            IDLE: begin
                if (in_valid) begin
                    bin_nxt   = in_data;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                acc_nxt = {acc_adj[BCD_W-2:0], bin[WIDTH-1]};
                bin_nxt = {bin[WIDTH-2:0], 1'b0};
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Highest nonzero digit decides the significant-digit count
    always_comb begin
        nd = 4'd1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc[i*4 +: 4] != 4'd0) begin
                nd = 4'(i + 1);
            end
        end
    end

    // Result is only exposed in DONE so partial accumulators never leak out
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign bcd       = out_valid ? acc : '0;
    assign ndigits   = out_valid ? nd : 4'd1;

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Directed scoreboard bench for fib_bcd_converter: latency, throughput,
// backpressure, mid-conversion reset and digit-boundary results.
module tb_fib_bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] bcd;
    logic [3:0]  ndigits;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [43:0] sb[$];
    logic [39:0] last_bcd;
    logic [3:0]  last_nd;

    fib_bcd_converter #(.WIDTH(32), .DIGITS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .ndigits   (ndigits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: repeated division by ten; {ndigits, bcd}
    function automatic logic [43:0] model(input logic [31:0] v);
        longint unsigned x;
        logic [39:0] b;
        logic [3:0]  n;
        x = 64'(v);
        b = '0;
        n = 4'd1;
        for (int i = 0; i < 10; i++) begin
            b[i*4 +: 4] = 4'(x % 10);
            if ((x % 10) != 0) n = 4'(i + 1);
            x = x / 10;
        end
        return {n, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a term and wait for acceptance; c_acc is the cycle count just before the accepting edge
    task automatic accept(input logic [31:0] v, input bit hold, output int c_acc);
        int n;
        in_valid = 1'b1;
        in_data  = v;
        sb.push_back(model(v));
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        c_acc = cyc;
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    // Wait for a result, check latency and the popped scoreboard entry
    task automatic collect(input string tag, input int c_acc, input bit chk_lat);
        int n;
        logic [43:0] e;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        if (chk_lat) chk({tag, "_latency"}, 64'(cyc - c_acc), 64'd33);
        chk({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk({tag, "_bcd"}, 64'(bcd), 64'(e[39:0]));
        chk({tag, "_ndigits"}, 64'(ndigits), 64'(e[43:40]));
        last_bcd = e[39:0];
        last_nd  = e[43:40];
    endtask

    initial begin
        int c1;
        int c2;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_ndigits", 64'(ndigits), 64'd1);
        rst_n = 1'b1;
        tick();

        // Zero input
        accept(32'd0, 1'b0, c1);
        collect("zero", c1, 1'b1);
        chk("zero_const_bcd", 64'(bcd), 64'h0);
        tick();

        // F30 then F31 back to back
        accept(32'd832040, 1'b1, c1);
        in_data = 32'd1346269;
        sb.push_back(model(32'd1346269));
        collect("f30", c1, 1'b1);
        chk("f30_const_bcd", 64'(bcd), 64'h0000832040);
        n = 0;
        tick();
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        c2 = cyc;
        chk("b2b_spacing", 64'(c2 - c1), 64'd34);
        tick();
        in_valid = 1'b0;
        collect("f31", c2, 1'b1);
        chk("f31_const_bcd", 64'(bcd), 64'h0001346269);
        tick();

        // Full scale and F47
        accept(32'hFFFFFFFF, 1'b0, c1);
        collect("full", c1, 1'b1);
        chk("full_const_bcd", 64'(bcd), 64'h4294967295);
        tick();
        accept(32'd2971215073, 1'b0, c1);
        collect("f47", c1, 1'b1);
        tick();

        // Backpressure: hold off consumption while a new term waits
        out_ready = 1'b0;
        accept(32'd514229, 1'b0, c1);
        collect("bp_first", c1, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd317811;
        sb.push_back(model(32'd317811));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_bcd_hold", 64'(bcd), 64'(last_bcd));
            chk("bp_nd_hold", 64'(ndigits), 64'(last_nd));
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_out_valid_high", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_idle_ready", 64'(in_ready), 64'd1);
        chk("bp_idle_no_valid", 64'(out_valid), 64'd0);
        c1 = cyc;
        tick();
        chk("bp_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        collect("bp_second", c1, 1'b1);
        tick();

        // Reset in the middle of SHIFT
        accept(32'd123456789, 1'b0, c1);
        while (cyc < c1 + 10) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_bcd", 64'(bcd), 64'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        accept(32'd5, 1'b0, c1);
        collect("after_rst", c1, 1'b1);
        chk("after_rst_const", 64'(bcd), 64'h5);
        tick();

        // Digit boundaries
        accept(32'd9, 1'b0, c1);
        collect("d9", c1, 1'b0);
        chk("d9_nd", 64'(ndigits), 64'd1);
        tick();
        accept(32'd10, 1'b0, c1);
        collect("d10", c1, 1'b0);
        chk("d10_nd", 64'(ndigits), 64'd2);
        tick();
        accept(32'd99, 1'b0, c1);
        collect("d99", c1, 1'b0);
        chk("d99_low", 64'(bcd[11:0]), 64'h099);
        tick();
        accept(32'd100, 1'b0, c1);
        collect("d100", c1, 1'b0);
        chk("d100_nd", 64'(ndigits), 64'd3);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
